uart_rx_sampler: RTL and testbench

//  Oversampling UART receiver front-end; feeds the UART peripheral's RX status register (data/finish/busy).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx_sampler.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default timing parameters and
// the three-point majority vote used by the oversampling receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  // 50 MHz / (9600 * 16)
  localparam int DEF_BAUD_DIV   = 326;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  // Two-out-of-three vote over the samples taken around mid-bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..BAUD_DIV-1 and emits a one-cycle tick
// on the wrap. A restart forces the count back to 0 so the receiver can align
// its bit grid to the detected start edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter: wraps at BAUD_DIV-1, restart realigns to 0.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A restart cycle never counts as a tick, so the first tick after an edge
  // lands a full BAUD_DIV cycles later.
  assign tick = (cnt == CNT_LAST) && !restart;

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver front-end (8N1, LSB first).
// Synchronises rx_line, validates the start bit by a mid-bit majority vote,
// shifts in the data bits, checks the stop bit and delivers the byte with a
// one-cycle finish strobe. A low stop bit raises frame_err and parks the
// receiver in BREAK until the line has been high for a full tick.
// Optional feature macro: UART_RX_PARITY_EN (8E1 frame with parity check).
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEF_BAUD_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] data,
  output logic                 finish,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  // Synchroniser and edge history
  logic sync1, sync2, rx_d;
  logic rx_s;

  // Timing
  logic          tick, restart, mid;
  logic [SW-1:0] sample_cnt;
  logic          v0, v1, vote;

  // Datapath
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  // FSM
  uart_state_t state, state_nxt;
  logic        start_ok, shift_en, stop_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
  logic par_en;
  logic par_bit;
`endif

  // Two-flop synchroniser plus one history flop for falling-edge detection;
  // all held at the idle level (1) in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rx_line;
      sync2 <= sync1;
      rx_d  <= sync2;
    end
  end

  assign rx_s = sync2;

  // The bit grid restarts on a start edge; in BREAK a low line keeps the
  // divider clear so the exit tick needs a full tick period of high line.
  assign restart = ((state == IDLE) && rx_d && !rx_s) ||
                   ((state == BREAK) && !rx_s);

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Tick position within the current bit; tick number = sample_cnt + 1.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      sample_cnt <= '0;
    end else if (tick && (state != IDLE)) begin
      sample_cnt <= (sample_cnt == S_LAST) ? '0 : sample_cnt + 1'b1;
    end
  end

  // Capture the first two vote samples; the third is the live line value.
  always_ff @(posedge clk) begin
    if (tick && (sample_cnt == S_V0)) begin
      v0 <= rx_s;
    end
    if (tick && (sample_cnt == S_V1)) begin
      v1 <= rx_s;
    end
  end

  assign mid  = tick && (sample_cnt == S_MID);
  assign vote = majority3(v0, v1, rx_s);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-bit decision strobes.
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_d && !rx_s) begin
          state_nxt = START;
        end
      end
      START: begin
        if (mid) begin
          if (!vote) begin
            start_ok  = 1'b1;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (mid) begin
          shift_en = 1'b1;
          if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (mid) begin
          par_en    = 1'b1;
          state_nxt = STOP;
        end
`else
        state_nxt = IDLE;
`endif
      end
      STOP: begin
        if (mid) begin
          if (vote) begin
            stop_ok   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s && tick) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Data bit counter, cleared whenever the receiver is idle.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // LSB-first shift register: each new bit enters at the MSB end.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shreg <= {vote, shreg[DATA_BITS-1:1]};
    end
  end

  // Registered outputs; reset overrides a coincident stop-bit decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      finish    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      finish    <= stop_ok;
      frame_err <= stop_bad;
      if (stop_ok) begin
        data <= shreg;
      end
      if (start_ok) begin
        busy <= 1'b1;
      end else if (stop_ok || stop_bad) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity bit capture.
  always_ff @(posedge clk) begin
    if (par_en) begin
      par_bit <= vote;
    end
  end

  // Even parity check, reported alongside the stop-bit outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= (stop_ok || stop_bad) && ((^shreg) ^ par_bit);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at BAUD_DIV=4, OVERSAMPLE=16 (64 clk/bit).
module tb_uart_rx_sampler;

  localparam int BAUD_DIV   = 4;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int BIT        = BAUD_DIV * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // busy spans start-bit mid to stop-bit mid
  localparam int BUSY_LEN = (9 + PB) * BIT;
  // 2 sync cycles + stop-bit start + 9 ticks to mid-bit decision + 1 register
  localparam int FIN_LAT  = 2 + (9 + PB) * BIT + 9 * BAUD_DIV + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rx_line;
  logic [DATA_BITS-1:0] data;
  logic                 finish;
  logic                 busy;
  logic                 frame_err;
  logic                 parity_err;

  uart_rx_sampler #(
    .BAUD_DIV   (BAUD_DIV),
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_line    (rx_line),
    .data       (data),
    .finish     (finish),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int         fin_n, fe_n, pe_n, busy_n, fin_cyc;
  int         pe_total = 0;
  logic [7:0] fin_d [8];

  always @(negedge clk) begin
    if (finish) begin
      if (fin_n < 8) fin_d[fin_n] = data;
      fin_n   = fin_n + 1;
      fin_cyc = cyc;
    end
    if (frame_err)  fe_n = fe_n + 1;
    if (parity_err) begin
      pe_n     = pe_n + 1;
      pe_total = pe_total + 1;
    end
    if (busy) busy_n = busy_n + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    fin_n   = 0;
    fe_n    = 0;
    pe_n    = 0;
    busy_n  = 0;
    fin_cyc = 0;
    for (int i = 0; i < 8; i++) fin_d[i] = 8'hEE;
  endtask

  task automatic send_bit(input logic v);
    rx_line = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit plus data bits, LSB first.
  task automatic send_data(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  // Whole frame with correct parity (when enabled) and nstop stop-bit periods.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int nstop);
    send_data(b);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    for (int i = 0; i < nstop; i++) send_bit(stop_v);
    rx_line = 1'b1;
  endtask

  int t0;

  initial begin
    clear_mon();
    rx_line = 1'b1;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_finish", 32'(finish), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    rst = 1'b0;
    idle(BIT);

    // 1: single 0xA5 frame
    clear_mon();
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1);
    idle(BIT);
    chk("a5_finish_cnt", 32'(fin_n), 32'd1);
    chk("a5_data_at_finish", 32'(fin_d[0]), 32'hA5);
    chk("a5_data_held", 32'(data), 32'hA5);
    chk("a5_frame_err", 32'(fe_n), 32'd0);
    chk("a5_busy_len", 32'(busy_n), 32'(BUSY_LEN));
    chk("a5_finish_latency", 32'(fin_cyc - t0), 32'(FIN_LAT));

    // 2: 30-clk glitch; only the first of the three votes sees it low
    clear_mon();
    rx_line = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    idle(2 * BIT);
    chk("glitch_busy", 32'(busy_n), 32'd0);
    chk("glitch_finish", 32'(fin_n), 32'd0);
    chk("glitch_data", 32'(data), 32'hA5);

    // 3: 0x3C with low stop bit, line low for two bit times, then 0x81
    clear_mon();
    send_data(8'h3C);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    send_bit(1'b0);
    send_bit(1'b0);
    idle(2 * BIT);
    chk("ferr_pulse", 32'(fe_n), 32'd1);
    chk("ferr_no_finish", 32'(fin_n), 32'd0);
    chk("ferr_data_kept", 32'(data), 32'hA5);
    chk("ferr_busy_len", 32'(busy_n), 32'(BUSY_LEN));
    clear_mon();
    send_frame(8'h81, 1'b1, 1);
    idle(BIT);
    chk("after_break_finish", 32'(fin_n), 32'd1);
    chk("after_break_data", 32'(data), 32'h81);

    // 4: back-to-back 0x00, 0xFF
    clear_mon();
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    idle(BIT);
    chk("b2b_finish_cnt", 32'(fin_n), 32'd2);
    chk("b2b_first", 32'(fin_d[0]), 32'h00);
    chk("b2b_second", 32'(fin_d[1]), 32'hFF);
    chk("b2b_ferr", 32'(fe_n), 32'd0);

    // 5: reset in the middle of data bit 4 of 0x5A (bit 4 = 1)
    clear_mon();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx_line = 1'b1;
    repeat (BIT / 2) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_data", 32'(data), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_finish", 32'(finish), 32'h0);
    idle(3 * BIT);
    chk("midrst_no_finish", 32'(fin_n), 32'd0);
    chk("midrst_no_ferr", 32'(fe_n), 32'd0);
    clear_mon();
    send_frame(8'h77, 1'b1, 1);
    idle(BIT);
    chk("post_rst_finish", 32'(fin_n), 32'd1);
    chk("post_rst_data", 32'(data), 32'h77);

`ifdef UART_RX_PARITY_EN
    // 6: 0x07 has odd weight, so even parity requires a 1
    clear_mon();
    send_data(8'h07);
    send_bit(1'b0);
    send_bit(1'b1);
    idle(BIT);
    chk("par0_finish", 32'(fin_n), 32'd1);
    chk("par0_parity_err", 32'(pe_n), 32'd1);
    chk("par0_data", 32'(data), 32'h07);
    clear_mon();
    send_data(8'h07);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(BIT);
    chk("par1_finish", 32'(fin_n), 32'd1);
    chk("par1_parity_err", 32'(pe_n), 32'd0);
`else
    chk("parity_err_never", 32'(pe_total), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
